// File: rtl/syndrome_coding_pkg.sv
// Shared constants and helpers for the syndrome-based bus coding path.
// Also used by the coset-leader table generator.
package syndrome_coding_pkg;

  localparam int unsigned SYN_W  = 6;
  localparam int unsigned CODE_W = 13;

  typedef logic [SYN_W-1:0]  syn_t;
  typedef logic [CODE_W-1:0] code_t;

  // Row r, bit b weights bus bit b; bus bit b is parity-check column 12-b.
  localparam code_t H_MATRIX [SYN_W] = '{
    13'b0100001010010,
    13'b1010001010001,
    13'b1001001001010,
    13'b0000101001001,
    13'b1000011000110,
    13'b1000001100101
  };

  function automatic syn_t syndrome(code_t bus);
    syn_t s;
    for (int r = 0; r < SYN_W; r++) s[r] = ^(H_MATRIX[r] & bus);
    return s;
  endfunction

  function automatic syn_t h_column(int b);
    syn_t c;
    for (int r = 0; r < SYN_W; r++) c[r] = H_MATRIX[r][b];
    return c;
  endfunction

  // Table address lists row 0 first (MSB); this mapping is its own inverse.
  function automatic syn_t reverse_rows(syn_t s);
    syn_t a;
    for (int r = 0; r < SYN_W; r++) a[SYN_W-1-r] = s[r];
    return a;
  endfunction

  function automatic logic [3:0] popcount(code_t v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < CODE_W; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/coset_leader_lut.sv
// Syndrome-to-minimum-weight coset leader table, shared by all channels.
// Ties resolve to the lowest parity-check column indices.
module coset_leader_lut
  import syndrome_coding_pkg::*;
(
  input  logic [SYN_W-1:0]  addr_i,
  output logic [CODE_W-1:0] leader_o
);

  // Unit columns plus the all-ones column bound every leader to weight 3.
  function automatic code_t min_leader(syn_t s);
    code_t l;
    logic  hit;
    l   = '0;
    hit = (s == '0);
    for (int a = CODE_W - 1; a >= 0; a--) begin
      if (!hit && h_column(a) == s) begin
        l[a] = 1'b1;
        hit  = 1'b1;
      end
    end
    for (int a = CODE_W - 1; a >= 0; a--) begin
      for (int b = a - 1; b >= 0; b--) begin
        if (!hit && (h_column(a) ^ h_column(b)) == s) begin
          l[a] = 1'b1;
          l[b] = 1'b1;
          hit  = 1'b1;
        end
      end
    end
    for (int a = CODE_W - 1; a >= 0; a--) begin
      for (int b = a - 1; b >= 0; b--) begin
        for (int c = b - 1; c >= 0; c--) begin
          if (!hit && (h_column(a) ^ h_column(b) ^ h_column(c)) == s) begin
            l[a] = 1'b1;
            l[b] = 1'b1;
            l[c] = 1'b1;
            hit  = 1'b1;
          end
        end
      end
    end
    return l;
  endfunction

  assign leader_o = min_leader(reverse_rows(addr_i));

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searching from the channel after the last
// accepted grant; the pointer moves only on accept.
module rr_arbiter #(
  parameter int unsigned NumCh = 4,
  parameter int unsigned ChW   = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [NumCh-1:0] req_i,
  input  logic             accept_i,
  output logic [NumCh-1:0] gnt_o,
  output logic [ChW-1:0]   gnt_idx_o
);

  logic [ChW-1:0] ptr_q, ptr_d;

  // Scan farthest-first so the requester closest to the pointer is written last.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    for (int k = int'(NumCh) - 1; k >= 0; k--) begin
      if (req_i[(int'(ptr_q) + k) % int'(NumCh)]) begin
        gnt_o     = NumCh'(1) << ((int'(ptr_q) + k) % int'(NumCh));
        gnt_idx_o = ChW'((int'(ptr_q) + k) % int'(NumCh));
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (accept_i) ptr_d = ChW'((int'(gnt_idx_o) + 1) % int'(NumCh));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/coset_encode_scheduler.sv
// Two-stage scheduler sharing one coset-leader table among NUM_CH bus encoders:
// accept + syndrome, then leader XOR into the channel's bus and toggle counting.
module coset_encode_scheduler
  import syndrome_coding_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CH_W   = $clog2(NUM_CH),
  parameter int unsigned CNT_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        req_valid,
  input  logic [NUM_CH*SYN_W-1:0]  req_msg,
  output logic [NUM_CH-1:0]        req_ready,
  output logic [NUM_CH*CODE_W-1:0] bus_out,
  output logic [NUM_CH-1:0]        bus_valid,
  input  logic                     cnt_clr,
  output logic [CNT_W-1:0]         toggle_cnt
);

  logic [NUM_CH-1:0] busy_mask, gnt, bus_valid_q;
  logic [CH_W-1:0]   gnt_idx, ch_q;
  logic              handshake, s2_valid_q;
  syn_t              syn_d, syn_q, lut_addr;
  code_t             leader;
  code_t             bus_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W+3:0]  cnt_sum;

  // The channel in stage 2 is blocked until its bus update lands (no forwarding).
  always_comb begin
    busy_mask = '0;
    if (s2_valid_q) busy_mask[ch_q] = 1'b1;
  end

  rr_arbiter #(
    .NumCh (NUM_CH),
    .ChW   (CH_W)
  ) u_arb (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .req_i     (req_valid & ~busy_mask),
    .accept_i  (handshake),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx)
  );

  assign req_ready = gnt;
  assign handshake = |gnt;
  assign syn_d     = req_msg[gnt_idx*SYN_W +: SYN_W] ^ syndrome(bus_q[gnt_idx]);
  assign lut_addr  = reverse_rows(syn_q);

  coset_leader_lut u_lut (
    .addr_i   (lut_addr),
    .leader_o (leader)
  );

  always_comb begin
    cnt_sum = {4'b0000, cnt_q} + (CNT_W+4)'(popcount(leader));
    cnt_d   = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (s2_valid_q) begin
      cnt_d = (cnt_sum[CNT_W+3:CNT_W] != 4'b0000) ? '1 : cnt_sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q  <= 1'b0;
      ch_q        <= '0;
      syn_q       <= '0;
      bus_valid_q <= '0;
      cnt_q       <= '0;
      for (int c = 0; c < NUM_CH; c++) bus_q[c] <= '0;
    end else begin
      s2_valid_q <= handshake;
      if (handshake) begin
        ch_q  <= gnt_idx;
        syn_q <= syn_d;
      end
      bus_valid_q <= '0;
      if (s2_valid_q) begin
        bus_q[ch_q]       <= bus_q[ch_q] ^ leader;
        bus_valid_q[ch_q] <= 1'b1;
      end
      cnt_q <= cnt_d;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_bus
    assign bus_out[c*CODE_W +: CODE_W] = bus_q[c];
  end

  assign bus_valid  = bus_valid_q;
  assign toggle_cnt = cnt_q;

endmodule

// File: tb/tb_coset_encode_scheduler.sv
// Self-checking bench: cycle-level reference built from the scheduling rules and
// a brute-force minimum-weight coset table.
module tb_coset_encode_scheduler;
  timeunit 1ns;
  timeprecision 1ps;

  localparam longint unsigned CntMax = 64'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [23:0] req_msg = '0;
  logic [3:0]  req_ready;
  logic [51:0] bus_out;
  logic [3:0]  bus_valid;
  logic        cnt_clr = 1'b0;
  logic [31:0] toggle_cnt;

  logic [3:0]  v4 = '0;
  logic [23:0] m4 = '0;
  logic [3:0]  rdy4;
  logic [51:0] bus4;
  logic [3:0]  bv4;
  logic        clr4 = 1'b0;
  logic [3:0]  cnt4;

  coset_encode_scheduler dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_msg(req_msg),
    .req_ready(req_ready), .bus_out(bus_out), .bus_valid(bus_valid),
    .cnt_clr(cnt_clr), .toggle_cnt(toggle_cnt)
  );

  coset_encode_scheduler #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .req_valid(v4), .req_msg(m4),
    .req_ready(rdy4), .bus_out(bus4), .bus_valid(bv4),
    .cnt_clr(clr4), .toggle_cnt(cnt4)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [5:0]  hcol [13];
  logic [12:0] leader_tbl [64];
  int          best_w [64];

  int               m_ptr;
  logic [12:0]      m_bus [4];
  bit               m_s2;
  int               m_ch;
  logic [5:0]       m_synq;
  longint unsigned  m_cnt;

  // Column i of H (bit r = row r) multiplies bus bit 12-i.
  function automatic logic [5:0] m_syn(logic [12:0] b);
    logic [5:0] s;
    s = '0;
    for (int i = 0; i < 13; i++) if (b[12-i]) s ^= hcol[i];
    return s;
  endfunction

  // Leader = numerically largest pattern among those of minimum weight.
  task automatic build_model();
    hcol = '{6'b110110, 6'b000001, 6'b000010, 6'b000100, 6'b001000, 6'b010000,
             6'b111111, 6'b100000, 6'b000011, 6'b001100, 6'b110000, 6'b010101,
             6'b101010};
    for (int s = 0; s < 64; s++) best_w[s] = 99;
    for (int e = 0; e < 8192; e++) begin
      logic [12:0] ev;
      logic [5:0]  sv;
      int          w;
      ev = 13'(e);
      sv = m_syn(ev);
      w  = $countones(ev);
      if (w <= best_w[sv]) begin
        best_w[sv]     = w;
        leader_tbl[sv] = ev;
      end
    end
  endtask

  task automatic model_reset();
    m_ptr = 0;
    m_s2  = 1'b0;
    m_ch  = 0;
    m_synq = '0;
    m_cnt = 0;
    for (int c = 0; c < 4; c++) m_bus[c] = '0;
  endtask

  task automatic apply_reset();
    req_valid = '0; req_msg = '0; cnt_clr = 1'b0;
    v4 = '0; m4 = '0; clr4 = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    vectors++;
    if (bus_out !== '0) begin
      miscompares++; $display("FAIL reset bus_out: got %h want 0", bus_out);
    end
    vectors++;
    if (bus_valid !== 4'b0 || req_ready !== 4'b0) begin
      miscompares++;
      $display("FAIL reset valid/ready: got %b/%b want 0000/0000", bus_valid, req_ready);
    end
    vectors++;
    if (toggle_cnt !== 32'd0 || cnt4 !== 4'd0) begin
      miscompares++; $display("FAIL reset toggle_cnt: got %0d/%0d want 0", toggle_cnt, cnt4);
    end
    rst_n = 1'b1;
    model_reset();
  endtask

  // One clock on the main DUT: drive, check grant, step, check bus/pulse/count.
  task automatic run_cycle(input logic [3:0] v, input logic [23:0] msgs, input logic clr,
                           output logic [3:0] got_ready);
    int          g;
    logic [3:0]  exp_ready, exp_bv;
    logic [5:0]  new_syn;
    logic [12:0] lead;
    req_valid = v; req_msg = msgs; cnt_clr = clr;
    #1;
    g = -1;
    for (int k = 0; k < 4; k++) begin
      int c;
      c = (m_ptr + k) % 4;
      if (g < 0 && v[c] && !(m_s2 && m_ch == c)) g = c;
    end
    exp_ready = (g >= 0) ? 4'(1 << g) : 4'b0;
    got_ready = req_ready;
    vectors++;
    if (req_ready !== exp_ready) begin
      miscompares++; $display("FAIL req_ready: got %b want %b", req_ready, exp_ready);
    end
    @(posedge clk);
    #1;
    exp_bv  = '0;
    new_syn = (g >= 0) ? (msgs[6*g +: 6] ^ m_syn(m_bus[g])) : 6'b0;
    if (m_s2) begin
      lead = leader_tbl[m_synq];
      m_bus[m_ch] ^= lead;
      exp_bv[m_ch] = 1'b1;
      m_cnt = m_cnt + 64'($countones(lead));
      if (m_cnt > CntMax) m_cnt = CntMax;
    end
    if (clr) m_cnt = 0;
    m_s2 = (g >= 0);
    if (g >= 0) begin
      m_ch   = g;
      m_synq = new_syn;
      m_ptr  = (g + 1) % 4;
    end
    for (int c = 0; c < 4; c++) begin
      vectors++;
      if (bus_out[13*c +: 13] !== m_bus[c]) begin
        miscompares++;
        $display("FAIL bus_out[ch%0d]: got %b want %b", c, bus_out[13*c +: 13], m_bus[c]);
      end
    end
    vectors++;
    if (bus_valid !== exp_bv) begin
      miscompares++; $display("FAIL bus_valid: got %b want %b", bus_valid, exp_bv);
    end
    vectors++;
    if (toggle_cnt !== m_cnt[31:0]) begin
      miscompares++; $display("FAIL toggle_cnt: got %0d want %0d", toggle_cnt, m_cnt);
    end
  endtask

  task automatic test_reset();
    apply_reset();
  endtask

  task automatic test_zero_msg();
    logic [3:0] r;
    apply_reset();
    run_cycle(4'b0001, 24'h0, 1'b0, r);
    vectors++;
    if (r !== 4'b0001) begin
      miscompares++; $display("FAIL zero_msg grant: got %b want 0001", r);
    end
    run_cycle(4'b0000, 24'h0, 1'b0, r);
    vectors++;
    if (bus_valid !== 4'b0001 || bus_out[12:0] !== 13'h0 || toggle_cnt !== 32'd0) begin
      miscompares++;
      $display("FAIL zero_msg result: got bv=%b bus=%h cnt=%0d want 0001/0/0",
               bus_valid, bus_out[12:0], toggle_cnt);
    end
    run_cycle(4'b0000, 24'h0, 1'b0, r);
    vectors++;
    if (bus_valid !== 4'b0000) begin
      miscompares++; $display("FAIL zero_msg pulse width: got %b want 0000", bus_valid);
    end
  endtask

  task automatic test_known_leaders();
    logic [3:0]  r;
    logic [23:0] m;
    apply_reset();
    m = '0;
    m[11:6] = 6'b100000;
    run_cycle(4'b0010, m, 1'b0, r);
    run_cycle(4'b0000, 24'h0, 1'b0, r);
    vectors++;
    if (bus_out[25:13] !== 13'b0000000100000 || toggle_cnt !== 32'd1) begin
      miscompares++;
      $display("FAIL leader_ch1: got bus=%b cnt=%0d want 0000000100000/1",
               bus_out[25:13], toggle_cnt);
    end
    m = '0;
    m[17:12] = 6'b110110;
    run_cycle(4'b0100, m, 1'b0, r);
    run_cycle(4'b0000, 24'h0, 1'b0, r);
    vectors++;
    if (bus_out[38:26] !== 13'b1000000000000 || toggle_cnt !== 32'd2) begin
      miscompares++;
      $display("FAIL leader_ch2: got bus=%b cnt=%0d want 1000000000000/2",
               bus_out[38:26], toggle_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] r;
    int         g, prev;
    run_cycle(4'b0000, 24'h0, 1'b0, r);
    run_cycle(4'b0000, 24'h0, 1'b0, r);
    prev = -1;
    for (int k = 0; k < 12; k++) begin
      run_cycle(4'b1111, 24'($urandom), 1'b0, r);
      g = -1;
      for (int c = 0; c < 4; c++) if (r[c]) g = c;
      vectors++;
      if ($countones(r) != 1 || (prev >= 0 && g != (prev + 1) % 4)) begin
        miscompares++;
        $display("FAIL back_to_back grant %0d: got %b want ch%0d", k, r, (prev + 1) % 4);
      end
      prev = g;
    end
  endtask

  task automatic test_single_channel();
    logic [3:0]  r;
    logic [23:0] m;
    logic [5:0]  acc;
    run_cycle(4'b0000, 24'h0, 1'b0, r);
    run_cycle(4'b0000, 24'h0, 1'b0, r);
    acc = '0;
    for (int k = 0; k < 12; k++) begin
      m = 24'($urandom);
      run_cycle(4'b1000, m, 1'b0, r);
      vectors++;
      if (r[3] !== 1'(k % 2 == 0)) begin
        miscompares++; $display("FAIL single ready %0d: got %b want %b", k, r[3], k % 2 == 0);
      end
      if (bus_valid[3]) begin
        vectors++;
        if (m_syn(bus_out[51:39]) !== acc) begin
          miscompares++;
          $display("FAIL single recover: got %b want %b", m_syn(bus_out[51:39]), acc);
        end
      end
      if (r[3]) acc = m[23:18];
    end
  endtask

  task automatic test_random();
    logic [3:0] r;
    for (int k = 0; k < 300; k++) begin
      run_cycle(4'($urandom), 24'($urandom), 1'($urandom_range(0, 15) == 0), r);
    end
    run_cycle(4'b0000, 24'h0, 1'b0, r);
  endtask

  task automatic test_reset_inflight();
    logic [3:0]  r;
    logic [23:0] m;
    m = 24'($urandom);
    m[17:12] = 6'b000111 ^ m_syn(m_bus[2]);
    run_cycle(4'b0000, 24'h0, 1'b0, r);
    run_cycle(4'b0100, m, 1'b0, r);
    req_valid = '0;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (bus_out !== '0 || bus_valid !== 4'b0 || toggle_cnt !== 32'd0) begin
      miscompares++;
      $display("FAIL inflight reset: got bus=%h bv=%b cnt=%0d want 0/0000/0",
               bus_out, bus_valid, toggle_cnt);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (bus_valid !== 4'b0 || bus_out !== '0) begin
      miscompares++;
      $display("FAIL inflight discard: got bv=%b bus=%h want 0000/0", bus_valid, bus_out);
    end
    rst_n = 1'b1;
    model_reset();
    run_cycle(4'b1010, 24'($urandom), 1'b0, r);
    vectors++;
    if (r !== 4'b0010) begin
      miscompares++; $display("FAIL post-reset grant: got %b want 0010", r);
    end
    run_cycle(4'b0000, 24'h0, 1'b0, r);
  endtask

  task automatic test_saturation();
    logic [12:0] b4m;
    int          c4m;
    logic [5:0]  tgt;
    b4m = '0;
    c4m = 0;
    tgt = 6'b000101;
    for (int k = 0; k < 9; k++) begin
      v4 = 4'b0001;
      m4 = '0;
      m4[5:0] = tgt ^ m_syn(b4m);
      @(posedge clk);
      #1;
      v4 = '0;
      @(posedge clk);
      #1;
      b4m ^= leader_tbl[tgt];
      c4m = c4m + $countones(leader_tbl[tgt]);
      if (c4m > 15) c4m = 15;
      vectors++;
      if (bus4[12:0] !== b4m || bv4 !== 4'b0001) begin
        miscompares++;
        $display("FAIL sat bus %0d: got %b/%b want %b/0001", k, bus4[12:0], bv4, b4m);
      end
      vectors++;
      if (cnt4 !== 4'(c4m)) begin
        miscompares++; $display("FAIL sat count %0d: got %0d want %0d", k, cnt4, c4m);
      end
    end
    vectors++;
    if (cnt4 !== 4'd15) begin
      miscompares++; $display("FAIL sat ceiling: got %0d want 15", cnt4);
    end
    v4 = 4'b0001;
    m4 = '0;
    m4[5:0] = tgt ^ m_syn(b4m);
    @(posedge clk);
    #1;
    v4 = '0;
    clr4 = 1'b1;
    @(posedge clk);
    #1;
    clr4 = 1'b0;
    vectors++;
    if (cnt4 !== 4'd0 || bv4 !== 4'b0001) begin
      miscompares++; $display("FAIL clr with update: got %0d/%b want 0/0001", cnt4, bv4);
    end
  endtask

  initial begin
    build_model();
    test_reset();
    test_zero_msg();
    test_known_leaders();
    test_back_to_back();
    test_single_channel();
    test_random();
    test_reset_inflight();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/coset_encode_scheduler.md
# coset_encode_scheduler

Round-robin scheduler that shares one syndrome→coset-leader lookup among NUM_CH independent bus-encoding channels. For each accepted 6-bit message it computes the syndrome against that channel's current 13-bit bus state. It then looks up the minimum-weight coset leader and XORs the leader into the channel's bus register. This minimises bus transitions while making the message recoverable as H·bus. It sits between the message sources and the physical bus drivers of the syndrome-based coding path.

## Interface
- NUM_CH, 4: number of requesting channels (2..8).
- CH_W, 2: index width, $clog2(NUM_CH).
- CNT_W, 32: width of the transition statistics counter.

- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_CH  per-channel message valid.
- req_msg  in  NUM_CH*6  per-channel message; channel c at [6c+5:6c]; bit r = syndrome row r.
- req_ready  out  NUM_CH  one-hot grant; combinational.
- bus_out  out  NUM_CH*13  per-channel encoded bus state; channel c at [13c+12:13c].
- bus_valid  out  NUM_CH  one-cycle pulse: the channel's bus_out was updated this cycle.
- cnt_clr  in  1  synchronous clear of toggle_cnt.
- toggle_cnt  out  CNT_W  saturating total of bus bit transitions issued.

## Operation
- Stage 1, accept:
  - Arbiter grants one channel g among req_valid & ~busy_mask.
  - Grant is round-robin, starting from the channel after the last grant.
  - req_ready[g]=1 only for the granted channel; it may depend on req_valid.
- On a handshake, register syn_q = req_msg[g] XOR (H·bus[g]), ch_q = g and s2_valid = 1.
  - Syndrome row r = XOR over i=0..12 of H[r][i] & bus[g][12-i].
  - Python index i maps to bus bit 12-i; the leader table uses the same mapping.
- Stage 2, update: when s2_valid is set:
  - Drive the shared LUT with syn_q.
  - bus[ch_q] <= bus[ch_q] XOR leader.
  - bus_valid[ch_q] <= 1.
  - toggle_cnt <= sat(toggle_cnt + popcount(leader)).
- busy_mask: the channel held in ch_q while s2_valid=1 is excluded from arbitration (RAW hazard on bus state). No forwarding is used.
- No requests, or only the busy channel requesting: no grant, s2_valid <= 0.
- Counter rules:
  - toggle_cnt saturates at 2^CNT_W-1.
  - cnt_clr and an update in the same cycle: the clear wins and the result is 0.
- Reset: every bus register is 0, bus_valid=0, s2_valid=0, the round-robin pointer points at channel 0, and toggle_cnt=0.
- Reset asserted with s2_valid=1: the in-flight word is discarded and no bus_valid pulse is issued. The requester treats the word as lost.

## Timing
- Accept at edge A → bus_out updated and bus_valid pulsed in the cycle after edge A+1. Latency is 2 edges.
- Throughput:
  - Aggregate: 1 word/cycle whenever two or more non-busy channels request.
  - Single channel: 1 word per 2 cycles. req_ready[c]=0 in the cycle after acceptance on c.
- bus_valid is high for exactly one cycle per accepted word.
- toggle_cnt updates on the same edge as bus_out.
- Round-robin pointer advances only on a handshake. Skipped or non-requesting channels do not advance it.

## Structure
- Shared package (syndrome_coding_pkg), which the LUT generator also uses:
  - H_MATRIX (6×13 parity-check constant).
  - SYN_W=6, CODE_W=13.
  - A syndrome-compute function.
- Sub-modules:
  - Instantiates the existing coset_leader_lut once, the shared resource.
  - rr_arbiter (NUM_CH-wide, masked request input, one-hot grant, pointer update on accept).
- The scheduler contains the stage registers, per-channel bus registers and the counter.

## Test plan
- Reset, then ch0 msg 6'b000000 → grant ch0; two edges later bus_out[ch0]=13'h0000, bus_valid[0] one-cycle pulse, toggle_cnt=0.
- From reset, ch1 msg 6'b100000 (LUT address 6'b000001) → bus_out[ch1]=13'b0000000100000, toggle_cnt=1. msg 6'b110110 on ch2 (LUT address 6'b011011) → bus_out[ch2]=13'b1000000000000, toggle_cnt=2.
- All four channels hold req_valid=1 continuously → grants 0,1,2,3,0,1,… one per cycle; each bus_valid pulses every 4th cycle.
- Only ch3 requests continuously → req_ready[3] alternates 1,0,1,0. Each word's syndrome uses the already-updated bus; check against a model with H·bus_out[3] == message after each pulse.
- CNT_W=4, repeatedly send weight-2 leaders → toggle_cnt saturates at 15. cnt_clr together with an update → 0.
- rst_n low while s2_valid=1 → all bus_out=0, no bus_valid pulse, toggle_cnt=0. Next grant after reset goes to the lowest requesting channel.
